usb_toggle_ctrl: RTL and testbench

//   Parametrised per-endpoint DATA0/DATA1 toggle engine for the device controller.
//   - Holds independent IN and OUT sequence bits for NUM_EP endpoints.
//   - Checks received OUT/SETUP data PIDs and flags duplicate packets.
//   - Supplies the data PID for each IN response; advances only on host ACK, with timeout.
//   - Handles SETUP, clear-halt, bus-reset and isochronous (always-DATA0) endpoints.

---
 rtl/usb_toggle_ctrl_if.sv | 45 ++++
 rtl/usb_toggle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_usb_toggle_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_toggle_ctrl_if.sv
`default_nettype none
// ============================================================================
// usb_toggle_ctrl_if : handshake/bus bundle for the DATA0/DATA1 toggle engine
// Rev 1.0
// ============================================================================
interface usb_toggle_ctrl_if #(
  parameter int NUM_EP = 4
);
  logic              bus_reset;
  logic              out_chk_valid;
  logic [3:0]        out_chk_ep;
  logic [3:0]        out_chk_pid;
  logic              out_chk_setup;
  logic              out_accept;
  logic              out_chk_ok;
  logic              out_chk_dup;
  logic              out_chk_err;
  logic              in_req_valid;
  logic [3:0]        in_req_ep;
  logic              in_pid_valid;
  logic [3:0]        in_pid;
  logic              in_err;
  logic              hs_valid;
  logic              hs_ack;
  logic              in_timeout;
  logic              clr_valid;
  logic [3:0]        clr_ep;
  logic [NUM_EP-1:0] dbg_tog_out;
  logic [NUM_EP-1:0] dbg_tog_in;

  modport master (
    output bus_reset, out_chk_valid, out_chk_ep, out_chk_pid, out_chk_setup,
           out_accept, in_req_valid, in_req_ep, hs_valid, hs_ack, clr_valid, clr_ep,
    input  out_chk_ok, out_chk_dup, out_chk_err, in_pid_valid, in_pid, in_err,
           in_timeout, dbg_tog_out, dbg_tog_in
  );

  modport slave (
    input  bus_reset, out_chk_valid, out_chk_ep, out_chk_pid, out_chk_setup,
           out_accept, in_req_valid, in_req_ep, hs_valid, hs_ack, clr_valid, clr_ep,
    output out_chk_ok, out_chk_dup, out_chk_err, in_pid_valid, in_pid, in_err,
           in_timeout, dbg_tog_out, dbg_tog_in
  );
endinterface
`default_nettype wire

// File: rtl/usb_toggle_ctrl.sv
`default_nettype none
// ============================================================================
// usb_toggle_ctrl : per-endpoint DATA0/DATA1 sequence-bit engine (OUT and IN)
// Rev 1.0
// ============================================================================
module usb_toggle_ctrl #(
  parameter int          NUM_EP      = 4,
  parameter logic [15:0] ISO_EP_MASK = 16'h0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  usb_toggle_ctrl_if.slave bus
);

  localparam logic [3:0]  c_PID_DATA0 = 4'h3;
  localparam logic [3:0]  c_PID_DATA1 = 4'hB;
  localparam logic [4:0]  c_NUM_EP    = 5'(NUM_EP);
  localparam logic [15:0] c_TMO_LAST  = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_WAIT_HS = 1'b1
  } state_t;

  // Full 16-entry storage so any 4-bit ep can index safely; only bits below
  // NUM_EP are ever written, the rest hold their reset value.
  logic [15:0] r_tog_out;
  logic [15:0] r_tog_in;
  state_t      r_state;
  logic [3:0]  r_ep;
  logic [15:0] r_timer;

  logic        r_out_ok;
  logic        r_out_dup;
  logic        r_out_err;
  logic        r_in_pid_valid;
  logic [3:0]  r_in_pid;
  logic        r_in_err;
  logic        r_in_timeout;

  logic w_out_ep_ok;
  logic w_out_d0;
  logic w_out_d1;
  logic w_out_bad;
  logic w_out_iso;
  logic w_out_match;
  logic w_setup_ok;
  logic w_in_ep_ok;
  logic w_in_iso;
  logic w_in_new;
  logic w_clr_ok;
  logic w_pend;

  assign w_out_ep_ok = {1'b0, bus.out_chk_ep} < c_NUM_EP;
  assign w_out_d0    = bus.out_chk_pid == c_PID_DATA0;
  assign w_out_d1    = bus.out_chk_pid == c_PID_DATA1;
  assign w_out_bad   = !w_out_ep_ok || !(w_out_d0 || w_out_d1);
  assign w_out_iso   = ISO_EP_MASK[bus.out_chk_ep];
  assign w_out_match = r_tog_out[bus.out_chk_ep] ? w_out_d1 : w_out_d0;
  assign w_setup_ok  = bus.out_chk_valid && !w_out_bad && bus.out_chk_setup && w_out_d0;

  assign w_in_ep_ok  = {1'b0, bus.in_req_ep} < c_NUM_EP;
  assign w_in_iso    = ISO_EP_MASK[bus.in_req_ep];
  assign w_in_new    = bus.in_req_valid && w_in_ep_ok;
  assign w_clr_ok    = bus.clr_valid && ({1'b0, bus.clr_ep} < c_NUM_EP);
  assign w_pend      = r_state == S_WAIT_HS;

  // Later assignments in this block take precedence: flips, then SETUP,
  // then clear-halt, with bus reset wrapping everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tog_out      <= '0;
      r_tog_in       <= '0;
      r_state        <= S_IDLE;
      r_ep           <= '0;
      r_timer        <= '0;
      r_out_ok       <= 1'b0;
      r_out_dup      <= 1'b0;
      r_out_err      <= 1'b0;
      r_in_pid_valid <= 1'b0;
      r_in_pid       <= c_PID_DATA0;
      r_in_err       <= 1'b0;
      r_in_timeout   <= 1'b0;
    end else begin
      r_out_ok       <= 1'b0;
      r_out_dup      <= 1'b0;
      r_out_err      <= 1'b0;
      r_in_pid_valid <= 1'b0;
      r_in_err       <= 1'b0;
      r_in_timeout   <= 1'b0;

      if (bus.bus_reset) begin
        r_tog_out <= '0;
        r_tog_in  <= '0;
        r_state   <= S_IDLE;
        r_timer   <= '0;
      end else begin
        if (bus.out_chk_valid) begin
          if (w_out_bad) begin
            r_out_err <= 1'b1;
          end else if (bus.out_chk_setup) begin
            if (w_out_d0) begin
              r_out_ok                  <= 1'b1;
              r_tog_out[bus.out_chk_ep] <= 1'b1;
            end else begin
              r_out_dup <= 1'b1;
            end
          end else if (w_out_iso) begin
            r_out_ok <= 1'b1;
          end else if (w_out_match) begin
            r_out_ok <= 1'b1;
            if (bus.out_accept) begin
              r_tog_out[bus.out_chk_ep] <= ~r_tog_out[bus.out_chk_ep];
            end
          end else begin
            r_out_dup <= 1'b1;
          end
        end

        if (bus.in_req_valid && !w_in_ep_ok) begin
          r_in_err <= 1'b1;
        end

        // A new valid IN silently replaces any pending one.
        if (w_in_new) begin
          r_in_pid_valid <= 1'b1;
          r_in_pid       <= (w_in_iso || !r_tog_in[bus.in_req_ep]) ? c_PID_DATA0 : c_PID_DATA1;
          r_ep           <= bus.in_req_ep;
          r_timer        <= '0;
          r_state        <= w_in_iso ? S_IDLE : S_WAIT_HS;
        end else if (w_pend) begin
          if (bus.hs_valid) begin
            if (bus.hs_ack && !ISO_EP_MASK[r_ep]) begin
              r_tog_in[r_ep] <= ~r_tog_in[r_ep];
            end
            r_state <= S_IDLE;
          end else if (r_timer == c_TMO_LAST) begin
            r_in_timeout <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        if (w_setup_ok) begin
          r_tog_in[bus.out_chk_ep] <= 1'b1;
          if (w_pend && !w_in_new && (r_ep == bus.out_chk_ep)) begin
            r_state      <= S_IDLE;
            r_in_timeout <= 1'b0;
          end
        end

        if (w_clr_ok) begin
          r_tog_out[bus.clr_ep] <= 1'b0;
          r_tog_in[bus.clr_ep]  <= 1'b0;
          if (w_pend && !w_in_new && (r_ep == bus.clr_ep)) begin
            r_state      <= S_IDLE;
            r_in_timeout <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.out_chk_ok   = r_out_ok;
  assign bus.out_chk_dup  = r_out_dup;
  assign bus.out_chk_err  = r_out_err;
  assign bus.in_pid_valid = r_in_pid_valid;
  assign bus.in_pid       = r_in_pid;
  assign bus.in_err       = r_in_err;
  assign bus.in_timeout   = r_in_timeout;
  assign bus.dbg_tog_out  = r_tog_out[NUM_EP-1:0];
  assign bus.dbg_tog_in   = r_tog_in[NUM_EP-1:0];

endmodule
`default_nettype wire

// File: tb/tb_usb_toggle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_usb_toggle_ctrl : directed bench for the DATA0/DATA1 toggle engine
// Rev 1.0
// ============================================================================
module tb_usb_toggle_ctrl;

  localparam int          c_NUM_EP = 4;
  localparam logic [15:0] c_ISO    = 16'h0008;
  localparam int          c_TMO    = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_to;

  usb_toggle_ctrl_if #(.NUM_EP(c_NUM_EP)) bus ();

  usb_toggle_ctrl #(
    .NUM_EP      (c_NUM_EP),
    .ISO_EP_MASK (c_ISO),
    .TIMEOUT_CYC (c_TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.bus_reset     = 1'b0;
    bus.out_chk_valid = 1'b0;
    bus.out_chk_ep    = 4'd0;
    bus.out_chk_pid   = 4'd0;
    bus.out_chk_setup = 1'b0;
    bus.out_accept    = 1'b0;
    bus.in_req_valid  = 1'b0;
    bus.in_req_ep     = 4'd0;
    bus.hs_valid      = 1'b0;
    bus.hs_ack        = 1'b0;
    bus.clr_valid     = 1'b0;
    bus.clr_ep        = 4'd0;
  endtask

  // Clock one edge with the current stimulus, then drop all stimulus.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic in_req(input logic [3:0] ep);
    bus.in_req_valid = 1'b1;
    bus.in_req_ep    = ep;
    tick();
  endtask

  task automatic hs(input logic ack);
    bus.hs_valid = 1'b1;
    bus.hs_ack   = ack;
    tick();
  endtask

  task automatic out_pkt(input logic [3:0] ep, input logic [3:0] pid,
                         input logic setup, input logic accept);
    bus.out_chk_valid = 1'b1;
    bus.out_chk_ep    = ep;
    bus.out_chk_pid   = pid;
    bus.out_chk_setup = setup;
    bus.out_accept    = accept;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_pid", bus.in_pid, 4'h3);
    chk("rst_pid_valid", bus.in_pid_valid, 1'b0);
    chk("rst_tog_out", bus.dbg_tog_out, 4'b0000);
    chk("rst_tog_in", bus.dbg_tog_in, 4'b0000);
    chk("rst_ok", bus.out_chk_ok, 1'b0);

    // 1: IN ep1 alternates DATA0/DATA1 on ACK
    in_req(4'd1);
    chk("t1_pv", bus.in_pid_valid, 1'b1);
    chk("t1_pid_a", bus.in_pid, 4'h3);
    hs(1'b1);
    chk("t1_tog_a", bus.dbg_tog_in, 4'b0010);
    in_req(4'd1);
    chk("t1_pid_b", bus.in_pid, 4'hB);
    hs(1'b1);
    chk("t1_tog_b", bus.dbg_tog_in, 4'b0000);
    in_req(4'd1);
    chk("t1_pid_c", bus.in_pid, 4'h3);
    hs(1'b0);
    chk("t1_nak_tog", bus.dbg_tog_in, 4'b0000);

    // 2: timeout after TIMEOUT_CYC silent cycles, then retry same PID
    in_req(4'd1);
    chk("t2_pid", bus.in_pid, 4'h3);
    n_to = 0;
    for (int i = 1; i <= c_TMO + 2; i++) begin
      tick();
      if (i == c_TMO) chk("t2_to_at", bus.in_timeout, 1'b1);
      n_to += int'(bus.in_timeout);
    end
    chk("t2_to_cnt", n_to, 1);
    in_req(4'd1);
    chk("t2_retry_pid", bus.in_pid, 4'h3);
    hs(1'b1);
    chk("t2_tog", bus.dbg_tog_in, 4'b0010);

    // 3: OUT sequence checking on ep2
    out_pkt(4'd2, 4'h3, 1'b0, 1'b1);
    chk("t3_ok_a", bus.out_chk_ok, 1'b1);
    chk("t3_dup_a", bus.out_chk_dup, 1'b0);
    chk("t3_tog_a", bus.dbg_tog_out, 4'b0100);
    out_pkt(4'd2, 4'h3, 1'b0, 1'b1);
    chk("t3_dup_b", bus.out_chk_dup, 1'b1);
    chk("t3_ok_b", bus.out_chk_ok, 1'b0);
    chk("t3_tog_b", bus.dbg_tog_out, 4'b0100);
    out_pkt(4'd2, 4'hB, 1'b0, 1'b0);
    chk("t3_ok_c", bus.out_chk_ok, 1'b1);
    chk("t3_tog_c", bus.dbg_tog_out, 4'b0100);

    // 4: SETUP on ep0 forces both toggles to 1
    out_pkt(4'd0, 4'h3, 1'b1, 1'b1);
    chk("t4_ok", bus.out_chk_ok, 1'b1);
    chk("t4_tog_out", bus.dbg_tog_out, 4'b0101);
    chk("t4_tog_in", bus.dbg_tog_in, 4'b0011);
    in_req(4'd0);
    chk("t4_pid", bus.in_pid, 4'hB);
    out_pkt(4'd0, 4'hB, 1'b1, 1'b1);
    chk("t4_dup", bus.out_chk_dup, 1'b1);
    hs(1'b0);
    chk("t4_tog_in_b", bus.dbg_tog_in, 4'b0011);

    // 5: clear-halt wins over a same-cycle ACK
    in_req(4'd1);
    chk("t5_pid", bus.in_pid, 4'hB);
    bus.clr_valid = 1'b1;
    bus.clr_ep    = 4'd1;
    hs(1'b1);
    chk("t5_tog_in", bus.dbg_tog_in, 4'b0001);
    chk("t5_tog_out", bus.dbg_tog_out, 4'b0101);
    hs(1'b1);
    chk("t5_idle_hs", bus.dbg_tog_in, 4'b0001);
    n_to = 0;
    for (int i = 0; i < c_TMO + 2; i++) begin
      tick();
      n_to += int'(bus.in_timeout);
    end
    chk("t5_no_to", n_to, 0);

    // 6: isochronous ep3 always DATA0; bus reset; invalid endpoints
    for (int i = 0; i < 3; i++) begin
      in_req(4'd3);
      chk("t6_iso_pid", bus.in_pid, 4'h3);
      hs(1'b1);
    end
    chk("t6_iso_tog", bus.dbg_tog_in, 4'b0001);
    in_req(4'd2);
    chk("t6_pid_ep2", bus.in_pid, 4'h3);
    bus.bus_reset = 1'b1;
    out_pkt(4'd2, 4'hB, 1'b0, 1'b1);
    chk("t6_rst_ok", bus.out_chk_ok, 1'b0);
    chk("t6_rst_tog_out", bus.dbg_tog_out, 4'b0000);
    chk("t6_rst_tog_in", bus.dbg_tog_in, 4'b0000);
    n_to = 0;
    for (int i = 0; i < c_TMO + 2; i++) begin
      tick();
      n_to += int'(bus.in_timeout);
    end
    chk("t6_rst_no_to", n_to, 0);
    in_req(4'd9);
    chk("t6_in_err", bus.in_err, 1'b1);
    chk("t6_in_pv", bus.in_pid_valid, 1'b0);
    out_pkt(4'd5, 4'h3, 1'b0, 1'b1);
    chk("t6_out_err_ep", bus.out_chk_err, 1'b1);
    out_pkt(4'd0, 4'h1, 1'b0, 1'b1);
    chk("t6_out_err_pid", bus.out_chk_err, 1'b1);
    chk("t6_out_err_ok", bus.out_chk_ok, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
